// File: rtl/sample_stim_gen.sv
// ============================================================================
//  Module   : sample_stim_gen
//  Brief    : Frame-paced multi-channel sample source (ramp / LFSR / constant)
//             with burst length and sticky done flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_stim_gen #(
    parameter int          WIDTH     = 16,
    parameter int          PERIOD    = 3125,
    parameter int          CHANNELS  = 1,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001,
    localparam int         c_ch_w    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  step,
    input  logic [WIDTH-1:0]  const_val,
    input  logic [15:0]       burst_len,
    output logic [WIDTH-1:0]  sample,
    output logic              write,
    output logic [c_ch_w-1:0] ch_index,
    output logic [15:0]       frame_cnt,
    output logic              done
);

    localparam int          c_cnt_w     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [31:0] c_taps      = 32'h8020_0003;
    localparam logic [31:0] c_seed      = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam logic [1:0]  c_mode_ramp = 2'd0;
    localparam logic [1:0]  c_mode_lfsr = 2'd1;
    localparam logic [1:0]  c_mode_cnst = 2'd2;

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic [c_ch_w-1:0]  r_chan;
    logic               r_en_d;
    logic [15:0]        r_burst;
    logic [1:0]         r_mode;
    logic [31:0]        r_lfsr;
    logic [WIDTH-1:0]   r_ramp [CHANNELS];

    logic               w_run;
    logic               w_wrap;
    logic               w_strobe;
    logic [c_ch_w-1:0]  w_ch;
    logic               w_last;
    logic [1:0]         w_mode;
    logic [15:0]        w_burst;
    logic [15:0]        w_frame_next;
    logic [WIDTH-1:0]   w_ramp_sel;
    logic [WIDTH-1:0]   w_value;

    assign w_run        = enable & ~done;
    assign w_wrap       = w_run && (r_cnt == c_cnt_w'(PERIOD - 1));
    // Channel 0 fires on the wrap; the rest follow back-to-back from r_chan.
    assign w_strobe     = w_wrap | (enable & r_busy);
    assign w_ch         = w_wrap ? '0 : r_chan;
    assign w_last       = (w_ch == c_ch_w'(CHANNELS - 1));
    assign w_mode       = w_wrap ? mode : r_mode;
    assign w_burst      = r_en_d ? r_burst : burst_len;
    assign w_frame_next = (frame_cnt == 16'hFFFF) ? 16'hFFFF : frame_cnt + 16'd1;

    always_comb begin
        w_ramp_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_ch == c_ch_w'(c)) begin
                w_ramp_sel = r_ramp[c];
            end
        end
    end

    always_comb begin
        w_value = '0;
        case (w_mode)
            c_mode_ramp: w_value = w_ramp_sel;
            c_mode_lfsr: w_value = r_lfsr[WIDTH-1:0];
            c_mode_cnst: w_value = const_val;
            default:     w_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_chan    <= '0;
            r_en_d    <= 1'b0;
            r_burst   <= '0;
            r_mode    <= c_mode_ramp;
            sample    <= '0;
            write     <= 1'b0;
            ch_index  <= '0;
            frame_cnt <= '0;
            done      <= 1'b0;
        end else begin
            r_en_d <= enable;
            write  <= 1'b0;
            if (!enable) begin
                r_cnt     <= '0;
                r_busy    <= 1'b0;
                r_chan    <= '0;
                frame_cnt <= '0;
                done      <= 1'b0;
            end else begin
                if (!r_en_d) begin
                    r_burst <= burst_len;
                end
                if (w_run) begin
                    r_cnt <= w_wrap ? '0 : r_cnt + c_cnt_w'(1);
                end
                if (w_strobe) begin
                    write    <= 1'b1;
                    ch_index <= w_ch;
                    sample   <= w_value;
                    if (w_wrap) begin
                        r_mode <= mode;
                    end
                    if (w_last) begin
                        r_busy    <= 1'b0;
                        r_chan    <= '0;
                        frame_cnt <= w_frame_next;
                        if ((w_burst != 16'd0) && (w_frame_next == w_burst)) begin
                            done <= 1'b1;
                        end
                    end else begin
                        r_busy <= 1'b1;
                        r_chan <= w_ch + c_ch_w'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_ramp[c] <= WIDTH'(c);
            end
        end else if (w_strobe && (w_mode == c_mode_ramp)) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_ch == c_ch_w'(c)) begin
                    r_ramp[c] <= r_ramp[c] + step;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= c_seed;
        end else if (w_strobe && (w_mode == c_mode_lfsr)) begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_taps : 32'd0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sample_stim_gen.sv
// ============================================================================
//  Module   : tb_sample_stim_gen
//  Brief    : Directed strobe-table bench for sample_stim_gen across several
//             channel counts and seeds.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sample_stim_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_a, en_z, en_b, en_c;
    logic [1:0]  mode;
    logic [15:0] step, const_val, burst_len;

    logic [15:0] a_sample, z_sample, b_sample, c_sample;
    logic        a_write, z_write, b_write, c_write;
    logic        a_ch, z_ch, c_ch;
    logic [1:0]  b_ch;
    logic [15:0] a_frame, z_frame, b_frame, c_frame;
    logic        a_done, z_done, b_done, c_done;

    always #5 clk = ~clk;

    sample_stim_gen #(.WIDTH(16), .PERIOD(8), .CHANNELS(1), .LFSR_SEED(32'h1)) u_a (
        .clk(clk), .reset(reset), .enable(en_a), .mode(mode), .step(step),
        .const_val(const_val), .burst_len(burst_len), .sample(a_sample),
        .write(a_write), .ch_index(a_ch), .frame_cnt(a_frame), .done(a_done));

    sample_stim_gen #(.WIDTH(16), .PERIOD(8), .CHANNELS(1), .LFSR_SEED(32'h0)) u_z (
        .clk(clk), .reset(reset), .enable(en_z), .mode(mode), .step(step),
        .const_val(const_val), .burst_len(burst_len), .sample(z_sample),
        .write(z_write), .ch_index(z_ch), .frame_cnt(z_frame), .done(z_done));

    sample_stim_gen #(.WIDTH(16), .PERIOD(8), .CHANNELS(3), .LFSR_SEED(32'h1)) u_b (
        .clk(clk), .reset(reset), .enable(en_b), .mode(mode), .step(step),
        .const_val(const_val), .burst_len(burst_len), .sample(b_sample),
        .write(b_write), .ch_index(b_ch), .frame_cnt(b_frame), .done(b_done));

    sample_stim_gen #(.WIDTH(16), .PERIOD(8), .CHANNELS(2), .LFSR_SEED(32'h1)) u_c (
        .clk(clk), .reset(reset), .enable(en_c), .mode(mode), .step(step),
        .const_val(const_val), .burst_len(burst_len), .sample(c_sample),
        .write(c_write), .ch_index(c_ch), .frame_cnt(c_frame), .done(c_done));

    typedef struct {
        int          edge_n;
        int          ch;
        logic [15:0] val;
    } strobe_t;

    strobe_t     exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cur_edge = 0;
    int          sel = 0;

    logic        mon_write;
    logic [15:0] mon_sample;
    int          mon_ch;

    always_comb begin
        mon_write  = a_write;
        mon_sample = a_sample;
        mon_ch     = int'(a_ch);
        case (sel)
            2: begin mon_write = b_write; mon_sample = b_sample; mon_ch = int'(b_ch); end
            3: begin mon_write = c_write; mon_sample = c_sample; mon_ch = int'(c_ch); end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cur_edge++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got %h want %h", name, cur_edge, act, exp);
        end
    endtask

    task automatic add(input int e, input int c, input logic [15:0] v);
        strobe_t s;
        s.edge_n = e;
        s.ch     = c;
        s.val    = v;
        exp_q.push_back(s);
    endtask

    // Every edge checks write against the table; strobe edges also check ch/sample.
    task automatic run_to(input int last_edge);
        int hit;
        while (cur_edge < last_edge) begin
            tick();
            hit = -1;
            foreach (exp_q[i]) if (exp_q[i].edge_n == cur_edge) hit = i;
            chk("write", 32'(mon_write), 32'(hit >= 0));
            if (hit >= 0) begin
                chk("ch_index", 32'(mon_ch), 32'(exp_q[hit].ch));
                chk("sample", 32'(mon_sample), 32'(exp_q[hit].val));
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en_a = 1'b0; en_z = 1'b0; en_b = 1'b0; en_c = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        exp_q.delete();
        cur_edge = 0;
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
    endfunction

    initial begin
        logic [31:0] s;
        int          wcount;

        reset = 1'b1;
        en_a = 1'b0; en_z = 1'b0; en_b = 1'b0; en_c = 1'b0;
        mode = 2'd0; step = 16'd1; const_val = 16'd0; burst_len = 16'd0;

        // Reset values and single-channel ramp
        sel = 0;
        do_reset();
        chk("rst_sample", 32'(a_sample), 32'h0);
        chk("rst_write", 32'(a_write), 32'h0);
        chk("rst_ch", 32'(a_ch), 32'h0);
        chk("rst_frame", 32'(a_frame), 32'h0);
        chk("rst_done", 32'(a_done), 32'h0);
        en_a = 1'b1;
        add(8, 0, 16'd0); add(16, 0, 16'd1); add(24, 0, 16'd2);
        run_to(30);
        chk("ramp_frame_cnt", 32'(a_frame), 32'd3);

        // Three channels, step 0x10
        do_reset();
        sel = 2; step = 16'h0010; en_b = 1'b1;
        add(8, 0, 16'h0000); add(9, 1, 16'h0001); add(10, 2, 16'h0002);
        add(16, 0, 16'h0010); add(17, 1, 16'h0011); add(18, 2, 16'h0012);
        run_to(20);

        // LFSR: seed 1 and seed 0 must match the software model
        do_reset();
        mode = 2'd1; en_a = 1'b1; en_z = 1'b1;
        s = 32'd1;
        for (int k = 1; k <= 4; k++) begin
            repeat (8) tick();
            chk("lfsr_write", 32'(a_write), 32'd1);
            chk("lfsr_seed1", 32'(a_sample), 32'(s[15:0]));
            chk("lfsr_seed0", 32'(z_sample), 32'(s[15:0]));
            s = lfsr_next(s);
        end

        // Burst of 3 frames, then restart via enable toggle
        do_reset();
        sel = 0; mode = 2'd0; step = 16'd1; burst_len = 16'd3; en_a = 1'b1;
        add(8, 0, 16'd0); add(16, 0, 16'd1); add(24, 0, 16'd2);
        run_to(24);
        chk("burst_done", 32'(a_done), 32'd1);
        chk("burst_frame", 32'(a_frame), 32'd3);
        wcount = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (a_write) wcount++;
        end
        chk("burst_quiet", 32'(wcount), 32'd0);
        chk("burst_done_sticky", 32'(a_done), 32'd1);
        en_a = 1'b0;
        tick();
        chk("dis_done", 32'(a_done), 32'd0);
        chk("dis_frame", 32'(a_frame), 32'd0);
        en_a = 1'b1;
        cur_edge = 0;
        exp_q.delete();
        add(8, 0, 16'd3);
        run_to(8);
        chk("restart_frame", 32'(a_frame), 32'd1);
        chk("restart_done", 32'(a_done), 32'd0);

        // Mode change mid-frame on two channels
        do_reset();
        sel = 3; burst_len = 16'd0; step = 16'd1; const_val = 16'hA5A5; mode = 2'd0;
        en_c = 1'b1;
        add(8, 0, 16'd0);
        run_to(8);
        mode = 2'd2;
        add(9, 1, 16'd1); add(16, 0, 16'hA5A5); add(17, 1, 16'hA5A5);
        run_to(20);
        mode = 2'd0;
        add(24, 0, 16'd1); add(25, 1, 16'd2);
        run_to(26);

        // Reset between channel 0 and channel 1 strobes of frame 2
        do_reset();
        sel = 3; en_c = 1'b1;
        add(8, 0, 16'd0); add(9, 1, 16'd1); add(16, 0, 16'd1);
        run_to(16);
        reset = 1'b1;
        tick();
        chk("midrst_write", 32'(c_write), 32'd0);
        chk("midrst_sample", 32'(c_sample), 32'd0);
        chk("midrst_done", 32'(c_done), 32'd0);
        chk("midrst_frame", 32'(c_frame), 32'd0);
        reset = 1'b0;
        cur_edge = 0;
        exp_q.delete();
        add(8, 0, 16'd0); add(9, 1, 16'd1);
        run_to(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
